gate_vector_checker: RTL and testbench

- Synthesizable stimulus-and-response engine for a 2-input combinational gate DUT (AND/OR family).
- Drives both gate inputs through all four vectors, waits for the response to settle, samples it, and compares it to a parameterized truth table.
- Reports per-vector failures, an error count and a pass flag.
- Serves as the hardware-side counterpart to gate stimulus benches, for on-chip or emulation self-test.

---
 rtl/gate_vector_checker_pkg.sv | 27 ++
 rtl/gate_vector_checker_timer.sv | 30 +++
 rtl/gate_vector_checker.sv | 176 +++++++++++++++++
 tb/tb_gate_vector_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared types, truth-table constants and vector helpers for the gate vector checker.
package gate_vector_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SKEW   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Truth tables indexed by {a,b}: bit 0 is vector 00, bit 3 is vector 11.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic vec_a(input logic [1:0] idx);
    return idx[1];
  endfunction

  function automatic logic vec_b(input logic [1:0] idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/gate_vector_checker_timer.sv
// Loadable down-counter with zero flag; times both the SKEW and SETTLE phases.
module gate_vector_timer
  import gate_vector_checker_pkg::*;
#(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;

  // Load takes priority over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Stimulus/response engine for a 2-input gate: walks vectors 00,01,10,11,
// skews stim_a ahead of stim_b, lets the response settle, samples and
// compares it against EXPECT_TT.
// Optional build macro GATE_VECTOR_CHECKER_HALT_ON_FAIL_EN: stop the run at
// the first mismatching vector instead of running all four.
//
// state  | meaning
// IDLE   | waiting for start
// SKEW   | stim_a applied, stim_b still at previous value
// SETTLE | both inputs stable, waiting for resp to settle
// SAMPLE | resp compared against EXPECT_TT at the closing edge
// DONE   | one-cycle done pulse, pass valid
module gate_vector_checker
  import gate_vector_checker_pkg::*;
#(
  parameter int unsigned SKEW_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [3:0]  EXPECT_TT     = TT_OR,
  parameter int unsigned TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       stim_a,
  output logic       stim_b,
  input  logic       resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx
);

  // Timer counts down to zero inclusive, so load one less than the phase length.
  localparam logic [TIMER_W-1:0] SKEW_LOAD   = TIMER_W'(SKEW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         vec_idx_q, vec_idx_d;
  logic               stim_a_q, stim_a_d;
  logic               stim_b_q, stim_b_d;
  logic [2:0]         err_q, err_d;
  logic [3:0]         fail_q, fail_d;
  logic               pass_q, pass_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               mismatch;

  gate_vector_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // X/Z on resp must count as a failure, hence the case inequality.
  assign mismatch = (resp !== EXPECT_TT[vec_idx_q]);

  // State and result registers; reset aborts any run with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_idx_q <= '0;
      stim_a_q  <= 1'b0;
      stim_b_q  <= 1'b0;
      err_q     <= '0;
      fail_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      stim_a_q  <= stim_a_d;
      stim_b_q  <= stim_b_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state, stimulus update, compare and timer control.
  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    stim_a_d  = stim_a_q;
    stim_b_d  = stim_b_q;
    err_d     = err_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SKEW;
          err_d     = '0;
          fail_d    = '0;
          pass_d    = 1'b0;
          vec_idx_d = 2'd0;
          stim_a_d  = vec_a(2'd0);
          tmr_load  = 1'b1;
          tmr_val   = SKEW_LOAD;
        end
      end

      SKEW: begin
        if (tmr_zero) begin
          state_d  = SETTLE;
          stim_b_d = vec_b(vec_idx_q);
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_d             = (err_q == 3'd4) ? err_q : err_q + 3'd1;
          fail_d[vec_idx_q] = 1'b1;
        end
`ifdef GATE_VECTOR_CHECKER_HALT_ON_FAIL_EN
        if (mismatch) begin
          state_d = DONE;
          pass_d  = 1'b0;
        end else
`endif
        if (vec_idx_q == 2'd3) begin
          state_d = DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d   = SKEW;
          vec_idx_d = vec_idx_q + 2'd1;
          stim_a_d  = vec_a(vec_idx_q + 2'd1);
          tmr_load  = 1'b1;
          tmr_val   = SKEW_LOAD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == SKEW) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign vec_idx   = vec_idx_q;
  assign stim_a    = stim_a_q;
  assign stim_b    = stim_b_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: a behavioural gate model (OR, AND,
// stuck-at-0, stuck-at-1) drives resp; table-driven runs plus reset-abort and
// start-ignore sequences.
module tb_gate_vector_checker;

  localparam int SKEW   = 2;
  localparam int SETTLE = 16;
  localparam int P      = SKEW + SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stim_a, stim_b, resp;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;

  int resp_mode;
  int n_pass = 0;
  int n_total = 0;

  gate_vector_checker #(
    .SKEW_CYCLES   (SKEW),
    .SETTLE_CYCLES (SETTLE),
    .EXPECT_TT     (4'b1110),
    .TIMER_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stim_a    (stim_a),
    .stim_b    (stim_b),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .vec_idx   (vec_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (resp_mode)
      0:       resp = stim_a | stim_b;
      1:       resp = stim_a & stim_b;
      2:       resp = 1'b0;
      default: resp = 1'b1;
    endcase
  end

  typedef struct {
    string      name;
    int         mode;
    logic [2:0] err;
    logic [3:0] fail;
    logic       pass;
    int         done_cyc;
    logic [1:0] idx;
    logic [1:0] stim;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One run from start; checks stimulus order, skew, done timing and results.
  task automatic run_check(input vec_t v, input bit poke_start);
    int dc;
    dc = 0;
    resp_mode = v.mode;
    @(negedge clk);
    chk({v.name, ":idle_busy"}, busy, 0);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 200 && dc == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && (n == 10 || n == 40)) start = 1'b1;
      if (n == 1) chk({v.name, ":busy_c1"}, busy, 1);
      for (int k = 1; k <= 4; k++)
        if (n == k * P && n < v.done_cyc)
          chk($sformatf("%s:stim_vec%0d", v.name, k - 1), {stim_a, stim_b}, k - 1);
      if (n < v.done_cyc && (n == 2 * P + 1 || n == 2 * P + SKEW))
        chk($sformatf("%s:skew_hold_c%0d", v.name, n), {stim_a, stim_b}, 2'b11);
      if (n < v.done_cyc && n == 2 * P + SKEW + 1)
        chk({v.name, ":skew_release"}, {stim_a, stim_b}, 2'b10);
      if (done) dc = n;
    end
    chk({v.name, ":done_cycle"}, dc, v.done_cyc);
    chk({v.name, ":err_count"}, err_count, v.err);
    chk({v.name, ":fail_vec"}, fail_vec, v.fail);
    chk({v.name, ":pass"}, pass, v.pass);
    chk({v.name, ":vec_idx"}, vec_idx, v.idx);
    chk({v.name, ":stim_end"}, {stim_a, stim_b}, v.stim);
    chk({v.name, ":busy_done"}, busy, 0);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ":done_pulse"}, done, 0);
    chk({v.name, ":pass_held"}, pass, v.pass);
  endtask

  vec_t tbl[4];

  initial begin
    int ndone;
    int nbusy;

`ifdef GATE_VECTOR_CHECKER_HALT_ON_FAIL_EN
    tbl[0] = '{"and_dut",  1, 3'd1, 4'b0010, 1'b0, 2 * P + 1, 2'd1, 2'b01};
    tbl[1] = '{"stuck0",   2, 3'd1, 4'b0010, 1'b0, 2 * P + 1, 2'd1, 2'b01};
    tbl[2] = '{"stuck1",   3, 3'd1, 4'b0001, 1'b0, P + 1,     2'd0, 2'b00};
    tbl[3] = '{"or_dut",   0, 3'd0, 4'b0000, 1'b1, 4 * P + 1, 2'd3, 2'b11};
`else
    tbl[0] = '{"and_dut",  1, 3'd2, 4'b0110, 1'b0, 4 * P + 1, 2'd3, 2'b11};
    tbl[1] = '{"stuck0",   2, 3'd3, 4'b1110, 1'b0, 4 * P + 1, 2'd3, 2'b11};
    tbl[2] = '{"stuck1",   3, 3'd1, 4'b0001, 1'b0, 4 * P + 1, 2'd3, 2'b11};
    tbl[3] = '{"or_dut",   0, 3'd0, 4'b0000, 1'b1, 4 * P + 1, 2'd3, 2'b11};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    resp_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:stim", {stim_a, stim_b}, 0);
    chk("reset:busy_done_pass", {busy, done, pass}, 0);
    chk("reset:err_count", err_count, 0);
    chk("reset:fail_vec", fail_vec, 0);
    chk("reset:vec_idx", vec_idx, 0);
    rst_n = 1'b1;

    run_check(tbl[3], 1'b0);
    for (int i = 0; i < 4; i++) run_check(tbl[i], 1'b0);

    // Reset during vector 2 SETTLE aborts the run asynchronously.
    resp_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2 * P + SKEW + 5; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort:pre_stim", {stim_a, stim_b}, 2'b10);
    chk("abort:pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort:stim", {stim_a, stim_b}, 0);
    chk("abort:busy_done_pass", {busy, done, pass}, 0);
    chk("abort:err_fail_idx", {err_count, fail_vec, vec_idx}, 0);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort:no_done", ndone, 0);
    run_check(tbl[3], 1'b0);

    // Start pulses while busy and during DONE are ignored.
    run_check(tbl[3], 1'b1);
    ndone = 0;
    nbusy = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("ignore:extra_done", ndone, 0);
    chk("ignore:extra_busy", nbusy, 0);
    chk("ignore:pass_held", pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
